rr_grant_arbiter: RTL and testbench

- Round-robin arbiter sitting directly upstream of the one-hot-to-binary encoder.
- Takes up to IN_SIZE level-sensitive request lines and produces one registered one-hot grant vector, which is the encoder's `in` input.
- A valid/ready handshake holds each grant stable until the consumer of the encoded index accepts it.
- Guarantees the encoder never sees a multi-hot vector; it sees all-zeros only when no grant is valid.

---
 rtl/rr_grant_arbiter_if.sv | 31 +++
 rtl/rr_grant_arbiter.sv | 114 +++++++++++
 tb/tb_rr_grant_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rr_grant_arbiter_if.sv
// rtl/rr_grant_arbiter_if.sv - request/grant handshake bundle for rr_grant_arbiter
// Ports carried:
//   req         : level-sensitive request lines, bit i = requester i
//   grant       : registered one-hot grant (all-zero when grant_valid=0)
//   grant_valid : grant holds a valid one-hot selection
//   grant_ready : downstream accepts the current grant
// Modports:
//   master : arbiter side (drives grant/grant_valid)
//   slave  : requester/consumer side (drives req/grant_ready)
interface rr_grant_arbiter_if #(
   parameter int IN_SIZE = 16
);
   logic [IN_SIZE-1:0] req;
   logic [IN_SIZE-1:0] grant;
   logic               grant_valid;
   logic               grant_ready;

   modport master (
      input  req,
      input  grant_ready,
      output grant,
      output grant_valid
   );

   modport slave (
      output req,
      output grant_ready,
      input  grant,
      input  grant_valid
   );
endinterface

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin arbiter producing a registered one-hot grant
// Purpose: feeds a one-hot-to-binary encoder; a grant is held stable until the
// consumer accepts it, then the next requester after the granted one wins.
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   bus : rr_grant_arbiter_if.master (req, grant, grant_valid, grant_ready)
module rr_grant_arbiter #(
   parameter  int OUT_SIZE = 4,
   localparam int IN_SIZE  = 1 << OUT_SIZE
) (
   input  logic                  clk,
   input  logic                  rst,
   rr_grant_arbiter_if.master    bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t               state, state_nx;
   logic [IN_SIZE-1:0]   grant_q, grant_nx;
   logic                 valid_q, valid_nx;
   logic [OUT_SIZE-1:0]  ptr_q, ptr_nx;

   logic [OUT_SIZE-1:0]  grant_idx;
   logic [OUT_SIZE-1:0]  search_base;
   logic [OUT_SIZE-1:0]  cand;
   logic [OUT_SIZE-1:0]  win_idx;
   logic                 win_found;

   // Binary index of the currently held grant (grant_q is one-hot or zero).
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < IN_SIZE; i++) begin
         if (grant_q[i]) grant_idx = i[OUT_SIZE-1:0];
      end
   end

   // On a handshake the pointer moves to the granted index in the same cycle,
   // so re-arbitration searches from the granted index rather than the old ptr.
   assign search_base = (state == GRANT) ? grant_idx : ptr_q;

   // Search upward from search_base+1; the OUT_SIZE-bit add wraps modulo
   // IN_SIZE, and the last candidate (offset IN_SIZE) is search_base itself,
   // which lets a sole requester be re-granted.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= IN_SIZE; i++) begin
         cand = search_base + i[OUT_SIZE-1:0];
         if (!win_found && bus.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_nx = state;
      grant_nx = grant_q;
      valid_nx = valid_q;
      ptr_nx   = ptr_q;
      case (state)
         IDLE: begin
            if (win_found) begin
               grant_nx = IN_SIZE'(1) << win_idx;
               valid_nx = 1'b1;
               state_nx = GRANT;
            end
         end
         GRANT: begin
            // Held unchanged while not accepted, regardless of req changes.
            if (bus.grant_ready) begin
               ptr_nx = grant_idx;
               if (win_found) begin
                  grant_nx = IN_SIZE'(1) << win_idx;
                  valid_nx = 1'b1;
                  state_nx = GRANT;
               end else begin
                  grant_nx = '0;
                  valid_nx = 1'b0;
                  state_nx = IDLE;
               end
            end
         end
         default: begin
            grant_nx = '0;
            valid_nx = 1'b0;
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         grant_q <= '0;
         valid_q <= 1'b0;
         ptr_q   <= OUT_SIZE'(IN_SIZE - 1);
      end else begin
         state   <= state_nx;
         grant_q <= grant_nx;
         valid_q <= valid_nx;
         ptr_q   <= ptr_nx;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_valid = valid_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - self-checking bench for rr_grant_arbiter
// Ports exercised: clk, rst, and the rr_grant_arbiter_if bundle.
module tb_rr_grant_arbiter;

   localparam int OUT_SIZE = 4;
   localparam int IN_SIZE  = 1 << OUT_SIZE;

   logic clk;
   logic rst;

   rr_grant_arbiter_if #(.IN_SIZE(IN_SIZE)) bus ();

   rr_grant_arbiter #(.OUT_SIZE(OUT_SIZE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [15:0] req;
      logic        ready;
      logic [15:0] grant;
      logic        valid;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;
   bit inv_on   = 1'b0;

   function automatic vec_t mk(logic r, logic [15:0] q, logic rd, logic [15:0] g, logic v);
      vec_t t;
      t.rst = r; t.req = q; t.ready = rd; t.grant = g; t.valid = v;
      return t;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Drive one cycle of stimulus, queue its expected post-edge outputs, then
   // compare once the edge has passed.
   task automatic apply(input vec_t v, input string name);
      vec_t e;
      rst             = v.rst;
      bus.req         = v.req;
      bus.grant_ready = v.ready;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({name, ".grant"}, bus.grant, e.grant);
      check({name, ".valid"}, {15'd0, bus.grant_valid}, {15'd0, e.valid});
   endtask

   // One-hot when valid, zero otherwise.
   always @(negedge clk) begin
      if (inv_on) begin
         n_checks++;
         if (bus.grant_valid ? $onehot(bus.grant) : (bus.grant === 16'h0000)) n_pass++;
         else $display("FAIL invariant: grant %h valid %b", bus.grant, bus.grant_valid);
      end
   end

   // Reference model: first set bit above base, wrapping, via doubled vector.
   function automatic int m_win(logic [15:0] r, int base);
      logic [31:0] d;
      d = {r, r};
      for (int k = base + 1; k <= base + 16; k++) begin
         if (d[k]) return k % 16;
      end
      return -1;
   endfunction

   function automatic int m_idx(logic [15:0] g);
      for (int k = 0; k < 16; k++) if (g[k]) return k;
      return 0;
   endfunction

   initial begin
      logic [15:0] m_grant;
      logic        m_valid;
      int          m_ptr;
      int          w;
      logic [15:0] q;
      logic        rd;

      rst = 1'b1; bus.req = '0; bus.grant_ready = 1'b0;

      // reset
      tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0));
      tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0));
      // single request, then sole-requester re-grant
      tbl.push_back(mk(0, 16'h0001, 1, 16'h0001, 1));
      tbl.push_back(mk(0, 16'h0001, 1, 16'h0001, 1));
      // rotation
      tbl.push_back(mk(0, 16'h8421, 1, 16'h0020, 1));
      tbl.push_back(mk(0, 16'h8421, 1, 16'h0400, 1));
      tbl.push_back(mk(0, 16'h8421, 1, 16'h8000, 1));
      tbl.push_back(mk(0, 16'h8421, 1, 16'h0001, 1));
      tbl.push_back(mk(0, 16'h8421, 1, 16'h0020, 1));
      // drain, ready while idle ignored
      tbl.push_back(mk(0, 16'h0000, 1, 16'h0000, 0));
      tbl.push_back(mk(0, 16'h0000, 1, 16'h0000, 0));
      // backpressure hold (ptr=5, search wraps to bit 1)
      tbl.push_back(mk(0, 16'h0006, 0, 16'h0002, 1));
      tbl.push_back(mk(0, 16'h0006, 0, 16'h0002, 1));
      tbl.push_back(mk(0, 16'h0006, 0, 16'h0002, 1));
      tbl.push_back(mk(0, 16'h0004, 0, 16'h0002, 1));
      tbl.push_back(mk(0, 16'h0004, 0, 16'h0002, 1));
      tbl.push_back(mk(0, 16'h0004, 1, 16'h0004, 1));
      // wrap-around
      tbl.push_back(mk(0, 16'h8000, 1, 16'h8000, 1));
      tbl.push_back(mk(0, 16'h8001, 1, 16'h0001, 1));
      tbl.push_back(mk(0, 16'h8001, 1, 16'h8000, 1));
      // drain to idle
      tbl.push_back(mk(0, 16'h0010, 1, 16'h0010, 1));
      tbl.push_back(mk(0, 16'h0000, 1, 16'h0000, 0));
      tbl.push_back(mk(0, 16'h0000, 1, 16'h0000, 0));
      tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("vec%0d", i));
         if (i == 1) inv_on = 1'b1;
      end

      // Reset mid-grant: ptr=4 so 0x0100 wins; reset with ready drops it.
      apply(mk(0, 16'h0100, 0, 16'h0100, 1), "mid.grant");
      apply(mk(0, 16'h0100, 0, 16'h0100, 1), "mid.hold");
      apply(mk(1, 16'h0101, 1, 16'h0000, 0), "mid.rst");
      apply(mk(0, 16'h0101, 0, 16'h0001, 1), "mid.after");
      // Granted bit drops during hold: still held, then drain.
      apply(mk(0, 16'h0000, 0, 16'h0001, 1), "drop.hold");
      apply(mk(0, 16'h0000, 1, 16'h0000, 0), "drop.drain");
      // ptr=0 with only bit 0 requesting re-grants 0 after a full wrap.
      apply(mk(0, 16'h0001, 0, 16'h0001, 1), "selfwrap");

      // Random phase against the reference model.
      apply(mk(1, 16'h0000, 0, 16'h0000, 0), "rnd.rst");
      m_grant = '0; m_valid = 1'b0; m_ptr = 15;
      for (int c = 0; c < 400; c++) begin
         q  = 16'($urandom) & 16'($urandom) & 16'($urandom);
         rd = ($urandom_range(0, 3) != 0);
         if (!m_valid) begin
            w = m_win(q, m_ptr);
            if (w >= 0) begin
               m_grant = 16'(1) << w;
               m_valid = 1'b1;
            end
         end else if (rd) begin
            m_ptr = m_idx(m_grant);
            w = m_win(q, m_ptr);
            if (w >= 0) m_grant = 16'(1) << w;
            else begin
               m_grant = '0;
               m_valid = 1'b0;
            end
         end
         apply(mk(0, q, rd, m_grant, m_valid), $sformatf("rnd%0d", c));
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
